// File: rtl/seg_scan_driver.sv
// seg_scan_driver: BCD conversion and 4-digit active-low 7-segment scan driver for the traffic-light display.
// Ports:
//   Clk          system clock (1 kHz in the traffic-light top)
//   Rst          asynchronous, active-high reset
//   en           display enable; 0 blanks all digits
//   val_a/val_b  direction-1/direction-2 countdowns in seconds (binary)
//   Seg          segments, active-low; Seg[0]=a .. Seg[6]=g, Seg[7]=dp
//   Sel          digit select, active-low one-cold; Sel[3]=A tens .. Sel[0]=B units
// Optional feature: define SEG_LZ_BLANK_EN to blank a zero tens digit (its Sel bit stays asserted).
module seg_scan_driver #(
    parameter int SCAN_DIV = 1,
    parameter int VAL_W    = 7
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic [VAL_W-1:0] val_a,
    input  logic [VAL_W-1:0] val_b,
    output logic [7:0]       Seg,
    output logic [3:0]       Sel
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SUB, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    pos_q, pos_d;
    logic [6:0]    rem_a_q, rem_a_d, rem_b_q, rem_b_d;
    logic [3:0]    tens_a_q, tens_a_d, tens_b_q, tens_b_d;
    logic [3:0]    disp_ta_q, disp_ta_d, disp_ua_q, disp_ua_d;
    logic [3:0]    disp_tb_q, disp_tb_d, disp_ub_q, disp_ub_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    sel_q, sel_d;
    logic          dwell_wrap, frame, lz_blank;
    logic [3:0]    digit;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    function automatic logic [6:0] sat99(input logic [VAL_W-1:0] v);
        sat99 = (32'(v) > 99) ? 7'd99 : 7'(v);
    endfunction

    // Scan counters and frame boundary; disabled display holds the scan at slot 0
    // and treats every cycle as a frame boundary so conversion keeps tracking inputs.
    always_comb begin
        dwell_wrap = dwell_q == DW'(SCAN_DIV - 1);
        dwell_d    = (!en || dwell_wrap) ? '0 : dwell_q + DW'(1);
        pos_d      = !en ? 2'd0 : (dwell_wrap ? pos_q + 2'd1 : pos_q);
        frame      = !en || (dwell_wrap && pos_q == 2'd3);
    end

    assign digit = (pos_q == 2'd0) ? disp_ta_q :
                   (pos_q == 2'd1) ? disp_ua_q :
                   (pos_q == 2'd2) ? disp_tb_q : disp_ub_q;

`ifdef SEG_LZ_BLANK_EN
    assign lz_blank = !pos_q[0] && digit == 4'd0;
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_d = (!en || lz_blank) ? 8'hFF : seg_code(digit);
        sel_d = !en ? 4'hF : ~(4'b1000 >> pos_q);
    end

    // Conversion FSM: snapshot, repeated subtract-by-ten, then an atomic copy
    // of both channels into the display registers so A and B never tear.
    always_comb begin
        state_d   = state_q;
        rem_a_d   = rem_a_q;
        rem_b_d   = rem_b_q;
        tens_a_d  = tens_a_q;
        tens_b_d  = tens_b_q;
        disp_ta_d = disp_ta_q;
        disp_ua_d = disp_ua_q;
        disp_tb_d = disp_tb_q;
        disp_ub_d = disp_ub_q;
        case (state_q)
            IDLE: state_d = frame ? LOAD : IDLE;
            LOAD: begin
                rem_a_d  = sat99(val_a);
                rem_b_d  = sat99(val_b);
                tens_a_d = 4'd0;
                tens_b_d = 4'd0;
                state_d  = SUB;
            end
            SUB: begin
                if (rem_a_q >= 7'd10) begin
                    rem_a_d  = rem_a_q - 7'd10;
                    tens_a_d = tens_a_q + 4'd1;
                end
                if (rem_b_q >= 7'd10) begin
                    rem_b_d  = rem_b_q - 7'd10;
                    tens_b_d = tens_b_q + 4'd1;
                end
                state_d = (rem_a_q < 7'd10 && rem_b_q < 7'd10) ? DONE : SUB;
            end
            DONE: begin
                disp_ta_d = tens_a_q;
                disp_ua_d = rem_a_q[3:0];
                disp_tb_d = tens_b_q;
                disp_ub_d = rem_b_q[3:0];
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            dwell_q   <= '0;
            pos_q     <= 2'd0;
            rem_a_q   <= 7'd0;
            rem_b_q   <= 7'd0;
            tens_a_q  <= 4'd0;
            tens_b_q  <= 4'd0;
            disp_ta_q <= 4'd0;
            disp_ua_q <= 4'd0;
            disp_tb_q <= 4'd0;
            disp_ub_q <= 4'd0;
            seg_q     <= 8'hFF;
            sel_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            pos_q     <= pos_d;
            rem_a_q   <= rem_a_d;
            rem_b_q   <= rem_b_d;
            tens_a_q  <= tens_a_d;
            tens_b_q  <= tens_b_d;
            disp_ta_q <= disp_ta_d;
            disp_ua_q <= disp_ua_d;
            disp_tb_q <= disp_tb_d;
            disp_ub_q <= disp_ub_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
        end
    end

    assign Seg = seg_q;
    assign Sel = sel_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: checks two seg_scan_driver instances (SCAN_DIV 1 and 4) against a cycle model and directed literals.
module tb_seg_scan_driver;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [7:0] ZT = LZ ? 8'hFF : 8'hC0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [6:0] val_a = 7'd0;
    logic [6:0] val_b = 7'd0;
    logic [7:0] seg1, seg4;
    logic [3:0] sel1, sel4;

    int pass = 0;
    int total = 0;

    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int         cnt [2], left [2], pa [2], pb [2];
    int         dta [2], dua [2], dtb [2], dub [2];
    bit         busy [2], ldp [2];
    logic [7:0] e_seg [2] = '{8'hFF, 8'hFF};
    logic [3:0] e_sel [2] = '{4'hF, 4'hF};

    seg_scan_driver #(.SCAN_DIV(1), .VAL_W(7)) dut1 (
        .Clk(clk), .Rst(rst), .en(en), .val_a(val_a), .val_b(val_b), .Seg(seg1), .Sel(sel1));
    seg_scan_driver #(.SCAN_DIV(4), .VAL_W(7)) dut4 (
        .Clk(clk), .Rst(rst), .en(en), .val_a(val_a), .val_b(val_b), .Seg(seg4), .Sel(sel4));

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    // Model: scan slot = (cycles since enable / dwell) mod 4; a conversion started at a
    // frame boundary samples the inputs one cycle later and publishes max-tens+2 cycles after that.
    task automatic step_model();
        for (int k = 0; k < 2; k++) begin
            int d, p, dig, n;
            bit fr, blank;
            d = (k == 0) ? 1 : 4;
            if (rst) begin
                cnt[k] = 0; busy[k] = 0; ldp[k] = 0; left[k] = 0;
                dta[k] = 0; dua[k] = 0; dtb[k] = 0; dub[k] = 0;
                e_seg[k] = 8'hFF; e_sel[k] = 4'hF;
            end else begin
                p = (cnt[k] / d) % 4;
                fr = !en || (cnt[k] % (4 * d) == 4 * d - 1);
                dig = (p == 0) ? dta[k] : (p == 1) ? dua[k] : (p == 2) ? dtb[k] : dub[k];
                blank = LZ && (p % 2 == 0) && dig == 0;
                e_sel[k] = en ? ~(4'b1000 >> p) : 4'hF;
                e_seg[k] = (!en || blank) ? 8'hFF : segtab[dig];
                cnt[k] = en ? (cnt[k] + 1) % (4 * d) : 0;
                if (ldp[k]) begin
                    pa[k] = sat(int'(val_a));
                    pb[k] = sat(int'(val_b));
                    n = (pa[k] / 10 > pb[k] / 10) ? pa[k] / 10 : pb[k] / 10;
                    left[k] = n + 2;
                    ldp[k] = 0;
                end else if (busy[k]) begin
                    left[k]--;
                    if (left[k] == 0) begin
                        dta[k] = pa[k] / 10; dua[k] = pa[k] % 10;
                        dtb[k] = pb[k] / 10; dub[k] = pb[k] % 10;
                        busy[k] = 0;
                    end
                end else if (fr) begin
                    busy[k] = 1;
                    ldp[k] = 1;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) step_model();

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        chk("model_seg1", seg1, e_seg[0]);
        chk("model_sel1", {4'h0, sel1}, {4'h0, e_sel[0]});
        chk("model_seg4", seg4, e_seg[1]);
        chk("model_sel4", {4'h0, sel4}, {4'h0, e_sel[1]});
    end

    task automatic wait_slot(input int k, input logic [3:0] s, input logic [7:0] g, input string nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (((k == 0) ? sel1 : sel4) == s) begin
                hit = 1;
                chk(nm, (k == 0) ? seg1 : seg4, g);
            end
        end
        if (!hit) begin
            total++;
            $display("FAIL %s: slot %b not selected within 20 cycles", nm, s);
        end
    endtask

    initial begin
        bit hit;
        repeat (5) @(negedge clk);
        chk("rst_seg", seg1, 8'hFF);
        chk("rst_sel", {4'h0, sel4}, 8'h0F);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("blank_seg", seg4, 8'hFF);
        chk("blank_sel", {4'h0, sel1}, 8'h0F);

        en = 1'b1; val_a = 7'd55; val_b = 7'd0;
        repeat (30) @(negedge clk);
        wait_slot(0, 4'b0111, 8'h92, "scan_a_tens");
        @(negedge clk); chk("scan_sel1", {4'h0, sel1}, 8'h0B); chk("scan_a_units", seg1, 8'h92);
        @(negedge clk); chk("scan_sel2", {4'h0, sel1}, 8'h0D); chk("scan_b_tens", seg1, ZT);
        @(negedge clk); chk("scan_sel3", {4'h0, sel1}, 8'h0E); chk("scan_b_units", seg1, 8'hC0);

        val_a = 7'd54;
        hit = 0;
        for (int i = 0; i < 44 && !hit; i++) begin
            @(negedge clk);
            if (sel4 == 4'b1011 && seg4 == 8'h99) hit = 1;
        end
        total++;
        if (hit) pass++;
        else $display("FAIL latency_a_units: 99 not seen in A units within 44 cycles, want 99");
        wait_slot(1, 4'b0111, 8'h92, "latency_a_tens");

        val_a = 7'd99; val_b = 7'd9;
        repeat (60) @(negedge clk);
        wait_slot(0, 4'b0111, 8'h90, "sat99_a_tens");
        wait_slot(0, 4'b1011, 8'h90, "sat99_a_units");
        wait_slot(0, 4'b1101, ZT, "b9_tens");
        wait_slot(0, 4'b1110, 8'h90, "b9_units");

        val_a = 7'd100; val_b = 7'd127;
        repeat (60) @(negedge clk);
        wait_slot(1, 4'b0111, 8'h90, "sat100_a_tens");
        wait_slot(1, 4'b1101, 8'h90, "sat127_b_tens");
        wait_slot(1, 4'b1110, 8'h90, "sat127_b_units");

        wait_slot(1, 4'b1101, 8'h90, "pre_toggle");
        en = 1'b0;
        @(negedge clk);
        chk("dis_seg", seg4, 8'hFF);
        chk("dis_sel", {4'h0, sel4}, 8'h0F);
        repeat (5) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("reen_sel4", {4'h0, sel4}, 8'h07);
        chk("reen_sel1", {4'h0, sel1}, 8'h07);

        val_a = 7'd5; val_b = 7'd0;
        repeat (60) @(negedge clk);
        wait_slot(0, 4'b0111, ZT, "lz_a_tens");
        wait_slot(0, 4'b1011, 8'h92, "lz_a_units");

        val_a = 7'd99; val_b = 7'd99;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_seg1", seg1, 8'hFF);
        chk("arst_sel1", {4'h0, sel1}, 8'h0F);
        chk("arst_seg4", seg4, 8'hFF);
        chk("arst_sel4", {4'h0, sel4}, 8'h0F);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sel", {4'h0, sel4}, 8'h07);
        chk("post_rst_zero", seg4, ZT);
        repeat (60) @(negedge clk);
        wait_slot(0, 4'b0111, 8'h90, "post_rst_99");

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
